mem_wait_ctrl: RTL
==================

MEM_WAIT_CTRL -- requirements
Module: mem_wait_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 64-bit words stored.
REQ-002 SHALL have parameter LAT, default 2: wait cycles between request acceptance and completion, range 0..15.
REQ-003 SHALL have port clk  input  1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port adr  input  64: byte address from the multi-cycle core.
REQ-006 SHALL have port MemRead  input  1: read request, level.
REQ-007 SHALL have port MemWrite  input  1: write request, level.
REQ-008 SHALL have port wdata  input  64: write data.
REQ-009 SHALL have port rdata  output  64: read data, registered.
REQ-010 SHALL have port ready  output  1: one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1: high while a request is pending.
REQ-012 SHALL have port err  output  1: misalignment flag, one-cycle pulse with ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 SHALL accept a request in IDLE when MemRead or MemWrite is high; latch adr, wdata, request type on that edge.
REQ-015 SHALL treat MemRead and MemWrite both high as a write.
REQ-016 SHALL go IDLE->WAIT on acceptance with LAT>0, loading the wait counter with LAT-1; IDLE->DONE directly when LAT=0.
REQ-017 SHALL decrement the counter each WAIT cycle and go WAIT->DONE when it equals 0.
REQ-018 SHALL perform the memory access on the edge entering DONE: write stores latched wdata; read loads rdata.
REQ-019 SHALL drive ready high for exactly the DONE cycle, then return to IDLE.
REQ-020 SHALL make request-to-ready latency LAT+1 cycles after the accepting edge.
REQ-021 SHALL drive busy high in WAIT and DONE, low in IDLE.
REQ-022 SHALL ignore MemRead/MemWrite changes while busy; adr/wdata changes after acceptance have no effect.
REQ-023 SHALL accept a new request in the IDLE cycle immediately following DONE (back-to-back throughput one access per LAT+2 cycles).
REQ-024 SHALL index memory with adr[3+log2(DEPTH)-1:3]; higher bits ignored (address wraps modulo DEPTH*8).
REQ-025 SHALL hold rdata unchanged after a read until the next read completes; writes do not modify rdata.
REQ-026 SHALL NOT reset memory contents; uninitialised words read as X in simulation.

Reset
REQ-027 SHALL on rst high force state IDLE, counter 0, rdata 0, ready 0, busy 0, err 0, asynchronously.
REQ-028 SHALL discard any pending request when rst asserts mid-operation; a pending write SHALL NOT modify memory.
REQ-029 SHALL accept requests from the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL compile misalignment checking only when macro MEM_ALIGN_CHECK_EN is defined.
REQ-031 With MEM_ALIGN_CHECK_EN: latched adr[2:0] != 0 completes with normal latency, err high with ready, write suppressed, rdata forced to 0 on read.
REQ-032 Without MEM_ALIGN_CHECK_EN: adr[2:0] ignored, err tied 0.

Verification
REQ-033 Reset: rst high 20 ns mid-WAIT of a write to 0x10 -> all outputs 0, later read of 0x10 does not return that write data.
REQ-034 LAT=2: write 0x1122334455667788 to adr 0x08, then read 0x08 -> ready exactly 3 cycles after each accept, rdata=0x1122334455667788.
REQ-035 Busy ignore: MemRead held high through a write to 0x18 -> single ready, no extra access, busy low one cycle before next accept.
REQ-036 Simultaneous MemRead=MemWrite=1 at 0x20 with 0xA5 -> treated as write, rdata unchanged; subsequent read returns 0xA5.
REQ-037 Wrap: DEPTH=256, write 0x5A at 0x800, read 0x000 -> rdata=0x5A; LAT=0 variant -> ready 1 cycle after accept.
REQ-038 With MEM_ALIGN_CHECK_EN: write 0xFF to 0x09 then read 0x08 -> err pulses with first ready, word at 0x08 unchanged; read of 0x0C -> rdata 0, err 1.

Source files
------------

// File: rtl/mem_wait_ctrl_if.sv
// Request/response bundle between the multi-cycle core (master) and the
// wait-state memory controller (slave).
interface mem_wait_ctrl_if;
    logic [63:0] adr;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output adr, MemRead, MemWrite, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  adr, MemRead, MemWrite, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Fixed-latency 64-bit word memory with a wait-state handshake for a multi-cycle core.
// Define MEM_ALIGN_CHECK_EN to flag (and suppress) accesses with adr[2:0] != 0.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite; request latched on the accepting edge
// WAIT  | counting down the remaining wait cycles
// DONE  | access performed on entry; ready (and err) high for this one cycle
module mem_wait_ctrl #(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_wait_ctrl_if.slave bus
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;

    logic [AW-1:0] idx_q;
    logic          wr_q;
    logic          mis_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q;

    logic          req;
    logic          req_wr;
    logic          req_mis;
    logic [AW-1:0] req_idx;
    logic          unused_adr_bits;

    logic          accept;
    logic          fire;
    logic          fire_wr;
    logic          fire_mis;
    logic [AW-1:0] fire_idx;
    logic [63:0]   fire_data;

    logic [63:0]   mem [DEPTH];

    // A simultaneous read+write request is a write.
    assign req     = bus.MemRead | bus.MemWrite;
    assign req_wr  = bus.MemWrite;
    assign req_idx = bus.adr[3 +: AW];

`ifdef MEM_ALIGN_CHECK_EN
    assign req_mis         = |bus.adr[2:0];
    assign unused_adr_bits = ^bus.adr[63:3+AW];
`else
    assign req_mis         = 1'b0;
    assign unused_adr_bits = ^{bus.adr[63:3+AW], bus.adr[2:0]};
`endif

    // With LAT=0 the access happens on the accepting edge itself, so the
    // memory port takes the live request instead of the latched copy.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        fire      = 1'b0;
        fire_wr   = wr_q;
        fire_mis  = mis_q;
        fire_idx  = idx_q;
        fire_data = wdata_q;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LAT == 0) begin
                        state_nxt = DONE;
                        fire      = 1'b1;
                        fire_wr   = req_wr;
                        fire_mis  = req_mis;
                        fire_idx  = req_idx;
                        fire_data = bus.wdata;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    fire      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q   <= req_idx;
                wr_q    <= req_wr;
                mis_q   <= req_mis;
                wdata_q <= bus.wdata;
            end
            if (fire && !fire_wr) begin
                rdata_q <= fire_mis ? 64'd0 : mem[fire_idx];
            end
        end
    end

    // Memory is never reset; the rst gate keeps a LAT=0 request seen during
    // reset from writing.
    always_ff @(posedge clk) begin
        if (fire && fire_wr && !fire_mis && !rst) begin
            mem[fire_idx] <= fire_data;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = (state == DONE);
    assign bus.busy  = (state != IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    assign bus.err = (state == DONE) & mis_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
